rx_ser: RTL and testbench
=========================

# rx_ser

Serial receive front end of the CDBUS receive path. Oversamples the synchronised `rx` line, recovers 8N1 characters (start, 8 data bits LSB first, stop), tracks bus idle, and keeps a running CRC-16/MODBUS over the current frame. It drives the `ser_*` inputs of the downstream byte/frame stage and honours that stage's wait-for-idle request.

## Interface
- `PERIOD_W`, default 16: width of the bit-period input.
- `clk`  in  1: system clock.
- `reset_n`  in  1: asynchronous, active-low reset.
- `rx`  in  1: asynchronous bus line; idle level is 1.
- `period`  in  PERIOD_W: bit time minus one, in clk cycles (T = period+1). Valid range period ≥ 3. Held stable while the bus is active.
- `idle_len`  in  4: idle threshold in bit times; 0 behaves as 1.
- `force_wait_idle`  in  1: one-cycle pulse; abandon the current character and ignore the line until the bus is idle.
- `bus_idle`  out  1: line has been high for at least idle_len·T cycles.
- `data`  out  8: last received byte.
- `crc_data`  out  16: CRC-16/MODBUS over all bytes since the last idle, including `data`.
- `data_clk`  out  1: one-cycle strobe; `data` and `crc_data` are valid in the same cycle.
- `frame_err`  out  1: one-cycle strobe; stop bit sampled low.

## Operation
- Input: 2-flop synchroniser on `rx`, giving `rx_s`; a previous-sample flop supplies falling-edge detection.
- Idle tracker, independent of the FSM:
  - A bit timer and a saturating 4-bit count of high bit times both clear while `rx_s`=0.
  - `bus_idle`=1 once the count reaches max(idle_len,1), i.e. idle_len·T consecutive high cycles.
  - `rx_s`=0 clears `bus_idle` on the next edge.
- CRC:
  - `crc_data` loads 0xFFFF in every cycle that `bus_idle`=1.
  - On each valid stop bit it is updated with `data` using reflected polynomial 0xA001, processed LSB first.
- FSM states:
  - WAIT_IDLE → READY when `bus_idle`=1.
  - READY → START on a falling edge of `rx_s`; the bit counter loads floor(T/2)−1.
  - START: at the mid-bit sample, `rx_s`=1 is a false start (→ READY); `rx_s`=0 → DATA with the counter reloaded to T−1.
  - DATA: 8 samples, one every T cycles, shifted in LSB first; then → STOP.
  - STOP: one sample after T cycles. If 1, pulse `data_clk` with new `data` and `crc_data`, then → READY. If 0, pulse `frame_err` with `data` and `crc_data` unchanged, then → WAIT_IDLE.
- `force_wait_idle`=1 forces WAIT_IDLE from any state at the next edge. No `data_clk` is produced for a partially received character, and `crc_data` is untouched.

## Timing
- Reset values: state WAIT_IDLE, `bus_idle`=0, `data`=0x00, `crc_data`=0xFFFF, `data_clk`=0, `frame_err`=0, idle count 0, synchroniser flops 1.
- Let t0 be the first cycle with `rx_s`=0, i.e. 2 cycles after the pin falls.
  - Bit i (0..7) is sampled at t0 + floor(T/2) + (i+1)·T.
  - The stop bit is sampled at t0 + floor(T/2) + 9T.
  - `data_clk` or `frame_err` is high in the cycle after the stop sample.
- Back-to-back characters: a new start is accepted from the cycle after the stop sample, with no dead time.
- `data_clk` is never high in two consecutive cycles. `data_clk` and `frame_err` are never high together.
- Simultaneous events:
  - A low `rx_s` in the cycle the idle count would reach threshold wins: `bus_idle` stays 0.
  - `force_wait_idle` together with a stop sample: the force wins, and no strobe is produced.
- `bus_idle` and CRC preset: `bus_idle` rises idle_len·T cycles after the last low `rx_s`. The CRC preset to 0xFFFF is visible one cycle later.
- Reset mid-character: all outputs return to reset values immediately. No strobe is produced after reset deasserts until the line has been idle.

## Test plan
- Reset with `rx`=1, period=15, idle_len=10 → `bus_idle` rises 160 cycles after reset release (plus 2 synchroniser cycles); `crc_data`=0xFFFF.
- Send "123456789" (0x31..0x39) back-to-back, then 0x37, 0x4B → 11 `data_clk` pulses in byte order. `crc_data`=0x4B37 after 0x39 and 0x0000 after 0x4B.
- Pulse `rx` low for 5 cycles (< T/2) with period=15 → FSM returns to READY; no `data_clk`, no `frame_err`.
- Send 0x55 with the stop bit driven low → one `frame_err`, `data_clk` stays 0. A following 0xA5 sent before idle is ignored; `data_clk` resumes only after `bus_idle`.
- Assert `force_wait_idle` during bit 4 of 0xC3 → no `data_clk`; the next byte after the idle gap is received and its `crc_data` is computed from the 0xFFFF seed.
- Sweep period ∈ {3, 15, 1023} with 0x00, 0xFF, 0x80 → data exact. Deassert and reassert `reset_n` mid-byte → outputs return to reset values and no strobe occurs before the next idle.

Source files
------------

// File: rtl/rx_ser.sv
// rx_ser: CDBUS serial receive front end (8N1 oversampling, idle, CRC-16/MODBUS)
// Ports: clk, reset_n (async low); rx line; period = T-1; idle_len in bit times;
//   force_wait_idle pulse; bus_idle, data, crc_data, data_clk, frame_err out.
module rx_ser #(
  parameter int PERIOD_W = 16
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                rx,
  input  logic [PERIOD_W-1:0] period,
  input  logic [3:0]          idle_len,
  input  logic                force_wait_idle,
  output logic                bus_idle,
  output logic [7:0]          data,
  output logic [15:0]         crc_data,
  output logic                data_clk,
  output logic                frame_err
);

  typedef enum logic [2:0] {
    WAIT_IDLE,
    READY,
    START,
    DATA,
    STOP
  } state_t;

  localparam logic [PERIOD_W-1:0] ONE = {{(PERIOD_W-1){1'b0}}, 1'b1};

  function automatic logic [15:0] crc_upd(
    input logic [15:0] c,
    input logic [7:0]  d
  );
    logic [15:0] r;
    r = c ^ {8'h00, d};
    for (int i = 0; i < 8; i++)
      r = r[0] ? ((r >> 1) ^ 16'hA001) : (r >> 1);
    return r;
  endfunction

  logic rx_m, rx_s, rx_p, fall;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
      rx_p <= 1'b1;
    end else begin
      rx_m <= rx;
      rx_s <= rx_m;
      rx_p <= rx_s;
    end
  end

  assign fall = rx_p & ~rx_s;

  logic [PERIOD_W-1:0] itmr;
  logic [3:0]          icnt;
  logic [3:0]          thr;
  logic [4:0]          icnt_inc;
  logic                itick;

  assign thr      = (idle_len == 4'd0) ? 4'd1 : idle_len;
  assign icnt_inc = {1'b0, icnt} + 5'd1;
  // >= so a period lowered while idle cannot strand the timer
  assign itick    = itmr >= period;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      itmr     <= '0;
      icnt     <= 4'd0;
      bus_idle <= 1'b0;
    end else if (!rx_s) begin
      itmr     <= '0;
      icnt     <= 4'd0;
      bus_idle <= 1'b0;
    end else if (itick) begin
      itmr <= '0;
      if (icnt != 4'hF)
        icnt <= icnt + 4'd1;
      if (icnt_inc >= {1'b0, thr})
        bus_idle <= 1'b1;
    end else begin
      itmr <= itmr + ONE;
    end
  end

  state_t              state, state_n;
  logic [PERIOD_W-1:0] bcnt, half;
  logic [2:0]          bidx;
  logic [7:0]          sh;
  logic                tick;
  logic                ld_half, ld_full, dec, shift, clr_idx;
  logic                fire, ferr;

  // floor(T/2)-1 with T = period+1
  assign half = (period >> 1) - {{(PERIOD_W-1){1'b0}}, ~period[0]};
  assign tick = bcnt == '0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      state <= WAIT_IDLE;
    else
      state <= state_n;
  end

  always_comb begin
    state_n = state;
    if (force_wait_idle) begin
      state_n = WAIT_IDLE;
    end else begin
      unique case (state)
        WAIT_IDLE: if (bus_idle) state_n = READY;
        READY:     if (fall) state_n = START;
        START:     if (tick) state_n = rx_s ? READY : DATA;
        DATA:      if (tick && bidx == 3'd7) state_n = STOP;
        STOP:      if (tick) state_n = rx_s ? READY : WAIT_IDLE;
        default:   state_n = WAIT_IDLE;
      endcase
    end
  end

  always_comb begin
    ld_half = 1'b0;
    ld_full = 1'b0;
    dec     = 1'b0;
    shift   = 1'b0;
    clr_idx = 1'b0;
    fire    = 1'b0;
    ferr    = 1'b0;
    if (!force_wait_idle) begin
      unique case (state)
        READY: ld_half = fall;
        START: begin
          dec     = ~tick;
          ld_full = tick & ~rx_s;
          clr_idx = tick;
        end
        DATA: begin
          dec     = ~tick;
          ld_full = tick;
          shift   = tick;
        end
        STOP: begin
          dec  = ~tick;
          fire = tick & rx_s;
          ferr = tick & ~rx_s;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bcnt      <= '0;
      bidx      <= 3'd0;
      sh        <= 8'h00;
      data      <= 8'h00;
      crc_data  <= 16'hFFFF;
      data_clk  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      if (ld_half)
        bcnt <= half;
      else if (ld_full)
        bcnt <= period;
      else if (dec)
        bcnt <= bcnt - ONE;
      if (clr_idx)
        bidx <= 3'd0;
      else if (shift)
        bidx <= bidx + 3'd1;
      if (shift)
        sh <= {rx_s, sh[7:1]};
      data_clk  <= fire;
      frame_err <= ferr;
      // seed from 0xFFFF if the bus counts as idle in the stop cycle
      if (fire) begin
        data     <= sh;
        crc_data <= crc_upd(bus_idle ? 16'hFFFF : crc_data, sh);
      end else if (bus_idle) begin
        crc_data <= 16'hFFFF;
      end
    end
  end

endmodule

// File: tb/tb_rx_ser.sv
// tb_rx_ser: directed bench for rx_ser
// 8N1 frames, idle, CRC, glitch, framing error, force, period sweep, reset
module tb_rx_ser;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        rx = 1'b1;
  logic [15:0] period = 16'd15;
  logic [3:0]  idle_len = 4'd10;
  logic        force_wait_idle = 1'b0;
  logic        bus_idle;
  logic [7:0]  data;
  logic [15:0] crc_data;
  logic        data_clk;
  logic        frame_err;

  rx_ser #(.PERIOD_W(16)) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .rx              (rx),
    .period          (period),
    .idle_len        (idle_len),
    .force_wait_idle (force_wait_idle),
    .bus_idle        (bus_idle),
    .data            (data),
    .crc_data        (crc_data),
    .data_clk        (data_clk),
    .frame_err       (frame_err)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  int n_clk = 0;
  int n_ferr = 0;
  int n_bad = 0;
  logic [7:0]  q_data[$];
  logic [15:0] q_crc[$];
  logic [7:0]  ferr_data;
  logic [15:0] ferr_crc;
  logic        prev_clk = 1'b0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (data_clk) begin
      q_data.push_back(data);
      q_crc.push_back(crc_data);
      n_clk++;
    end
    if (frame_err) begin
      n_ferr++;
      ferr_data = data;
      ferr_crc = crc_data;
    end
    if ((data_clk && frame_err) || (data_clk && prev_clk))
      n_bad++;
    prev_clk = data_clk;
  end

  task automatic clear_mon();
    q_data.delete();
    q_crc.delete();
    n_clk = 0;
    n_ferr = 0;
  endtask

  task automatic gap();
    repeat (2 * (int'(period) + 1) + 5) @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int lim = 12 * (int'(period) + 1) + 50;
    int n = 0;
    while (!bus_idle && n < lim) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!bus_idle)
      check("idle_timeout", 32'(bus_idle), 32'd1);
  endtask

  // ev_bit: data bit index for an event (-1 none); ev_kind 0 force, 1 reset
  task automatic send_byte(input logic [7:0] b, input bit stop_ok,
                           input int ev_bit, input int ev_kind);
    int t = int'(period) + 1;
    logic [9:0] fr = {stop_ok, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      for (int c = 0; c < t; c++) begin
        rx = fr[i];
        if (ev_bit >= 0 && i == ev_bit + 1) begin
          if (ev_kind == 0) begin
            force_wait_idle = (c == 2);
          end else begin
            if (c == 2) reset_n = 1'b0;
            if (c == 4) begin
              check("rst_bus_idle", 32'(bus_idle), 32'd0);
              check("rst_data", 32'(data), 32'h00);
              check("rst_crc", 32'(crc_data), 32'hFFFF);
              check("rst_data_clk", 32'(data_clk), 32'd0);
              check("rst_frame_err", 32'(frame_err), 32'd0);
            end
            if (c == 5) reset_n = 1'b1;
          end
        end
        @(posedge clk);
        #1;
      end
    end
    force_wait_idle = 1'b0;
    rx = 1'b1;
  endtask

  logic [7:0] b2b[11] = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36,
                          8'h37, 8'h38, 8'h39, 8'h37, 8'h4B};
  logic [15:0] sweep_p[3] = '{16'd3, 16'd15, 16'd1023};
  logic [7:0]  sweep_b[3] = '{8'h00, 8'hFF, 8'h80};

  initial begin
    int n;
    #1 reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_bus_idle", 32'(bus_idle), 32'd0);
    check("reset_data", 32'(data), 32'h00);
    check("reset_crc", 32'(crc_data), 32'hFFFF);
    check("reset_data_clk", 32'(data_clk), 32'd0);
    check("reset_frame_err", 32'(frame_err), 32'd0);

    @(negedge clk);
    reset_n = 1'b1;
    n = 0;
    while (!bus_idle && n < 400) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("idle_rise_window", 32'(n >= 160 && n <= 162), 32'd1);
    @(posedge clk);
    #1;
    check("idle_crc_preset", 32'(crc_data), 32'hFFFF);

    clear_mon();
    for (int i = 0; i < 11; i++)
      send_byte(b2b[i], 1'b1, -1, 0);
    gap();
    check("b2b_count", 32'(n_clk), 32'd11);
    for (int i = 0; i < 11; i++)
      check($sformatf("b2b_data%0d", i),
            (i < q_data.size()) ? 32'(q_data[i]) : 32'hDEAD,
            32'(b2b[i]));
    check("crc_check_value",
          (q_crc.size() > 8) ? 32'(q_crc[8]) : 32'hDEAD, 32'h4B37);
    check("crc_residue",
          (q_crc.size() > 10) ? 32'(q_crc[10]) : 32'hDEAD, 32'h0000);

    wait_idle();
    clear_mon();
    rx = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rx = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    check("glitch_no_clk", 32'(n_clk), 32'd0);
    check("glitch_no_ferr", 32'(n_ferr), 32'd0);
    send_byte(8'h5A, 1'b1, -1, 0);
    gap();
    check("after_glitch_count", 32'(n_clk), 32'd1);
    check("after_glitch_data", 32'(data), 32'h5A);

    wait_idle();
    clear_mon();
    send_byte(8'h55, 1'b0, -1, 0);
    send_byte(8'hA5, 1'b1, -1, 0);
    gap();
    check("ferr_count", 32'(n_ferr), 32'd1);
    check("ferr_no_clk", 32'(n_clk), 32'd0);
    check("ferr_data_kept", 32'(ferr_data), 32'h5A);
    check("ferr_crc_kept", 32'(ferr_crc), 32'hFFFF);
    wait_idle();
    send_byte(8'h11, 1'b1, -1, 0);
    gap();
    check("resume_count", 32'(n_clk), 32'd1);
    check("resume_data", 32'(data), 32'h11);

    wait_idle();
    clear_mon();
    send_byte(8'hC3, 1'b1, 4, 0);
    gap();
    check("force_no_clk", 32'(n_clk), 32'd0);
    check("force_no_ferr", 32'(n_ferr), 32'd0);
    wait_idle();
    send_byte(8'h00, 1'b1, -1, 0);
    gap();
    check("force_next_count", 32'(n_clk), 32'd1);
    check("force_next_data", 32'(data), 32'h00);
    check("force_next_crc", 32'(crc_data), 32'h40BF);

    for (int p = 0; p < 3; p++) begin
      wait_idle();
      period = sweep_p[p];
      clear_mon();
      for (int i = 0; i < 3; i++)
        send_byte(sweep_b[i], 1'b1, -1, 0);
      gap();
      for (int i = 0; i < 3; i++)
        check($sformatf("sweep_p%0d_b%0d", sweep_p[p], i),
              (i < q_data.size()) ? 32'(q_data[i]) : 32'hDEAD,
              32'(sweep_b[i]));
    end

    wait_idle();
    period = 16'd15;
    send_byte(8'h3C, 1'b1, -1, 0);
    repeat (8) @(posedge clk);
    #1;
    clear_mon();
    send_byte(8'h96, 1'b1, 3, 1);
    gap();
    check("rst_mid_no_clk", 32'(n_clk), 32'd0);
    check("rst_mid_no_ferr", 32'(n_ferr), 32'd0);
    wait_idle();
    check("rst_idle_no_clk", 32'(n_clk), 32'd0);
    send_byte(8'h81, 1'b1, -1, 0);
    gap();
    check("rst_after_count", 32'(n_clk), 32'd1);
    check("rst_after_data", 32'(data), 32'h81);

    check("strobe_rules", 32'(n_bad), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
